// File: rtl/dx_spi3w_master.sv
// Half-duplex 3-wire SPI master: parallel command/response in, CSN/SCLK/SDIO out.
// Mode 0 SCLK, MSB-first header then data; SDIO is released for the read turnaround and read data.
//   state      | meaning
//   S_IDLE     | waiting for cmd_valid, csn high
//   S_CS_SETUP | csn low, header MSB already on SDIO
//   S_HDR      | shifting header bits out
//   S_TURN     | read only: one SCLK-low half period with SDIO released
//   S_DATA     | write data out, or read data sampled on SCLK rise
//   S_CS_HOLD  | SCLK low, SDIO released, csn still low
//   S_CS_GAP   | csn high, response issued on first cycle
module dx_spi3w_master #(
  parameter int CMD_WIDTH  = 8,
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [CMD_WIDTH-1:0]  cmd_hdr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  busy,
  output logic                  spi_csn,
  output logic                  spi_sclk,
  output logic                  sdio_t,
  output logic                  sdio_o,
  input  logic                  sdio_i
);

  localparam int MAX_W = (CMD_WIDTH > DATA_WIDTH) ? CMD_WIDTH : DATA_WIDTH;
  localparam int BIT_W = $clog2(MAX_W + 1);
  localparam logic [7:0]       DIV_LOAD  = 8'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] HDR_LAST  = BIT_W'(CMD_WIDTH - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CS_SETUP, S_HDR, S_TURN, S_DATA, S_CS_HOLD, S_CS_GAP
  } state_t;

  state_t                state_q, state_d;
  logic [7:0]            div_q, div_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic                  phase_q, phase_d;
  logic                  is_read_q, is_read_d;
  logic [CMD_WIDTH-1:0]  hdr_q, hdr_d;
  logic [DATA_WIDTH-1:0] wd_q, wd_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  busy_q, busy_d;
  logic                  csn_q, csn_d;
  logic                  sclk_q, sclk_d;
  logic                  sdio_t_q, sdio_t_d;
  logic                  sdio_o_q, sdio_o_d;
  logic                  tc;

  assign tc = (div_q == 8'd0);

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    bit_d       = bit_q;
    phase_d     = phase_q;
    is_read_d   = is_read_q;
    hdr_d       = hdr_q;
    wd_d        = wd_q;
    rx_d        = rx_q;
    sdio_o_d    = sdio_o_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;

    if (state_q != S_IDLE && !tc) div_d = div_q - 8'd1;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d   = S_CS_SETUP;
          div_d     = DIV_LOAD;
          hdr_d     = cmd_hdr;
          wd_d      = cmd_wdata;
          is_read_d = cmd_hdr[CMD_WIDTH-1];
          sdio_o_d  = cmd_hdr[CMD_WIDTH-1];
          rx_d      = '0;
        end
      end
      S_CS_SETUP: begin
        if (tc) begin
          state_d = S_HDR;
          div_d   = DIV_LOAD;
          phase_d = 1'b0;
          bit_d   = HDR_LAST;
        end
      end
      S_HDR: begin
        if (tc) begin
          div_d = DIV_LOAD;
          if (!phase_q) begin
            phase_d = 1'b1;
          end else if (bit_q == '0) begin
            phase_d = 1'b0;
            if (is_read_q) begin
              state_d  = S_TURN;
              sdio_o_d = 1'b0;
            end else begin
              state_d  = S_DATA;
              bit_d    = DATA_LAST;
              sdio_o_d = wd_q[DATA_WIDTH-1];
            end
          end else begin
            phase_d  = 1'b0;
            bit_d    = bit_q - BIT_W'(1);
            hdr_d    = hdr_q << 1;
            sdio_o_d = hdr_d[CMD_WIDTH-1];
          end
        end
      end
      S_TURN: begin
        if (tc) begin
          state_d = S_DATA;
          div_d   = DIV_LOAD;
          phase_d = 1'b0;
          bit_d   = DATA_LAST;
        end
      end
      S_DATA: begin
        if (tc) begin
          div_d = DIV_LOAD;
          if (!phase_q) begin
            phase_d = 1'b1;
            // sample on the same edge that raises SCLK
            if (is_read_q) begin
              rx_d    = rx_q << 1;
              rx_d[0] = sdio_i;
            end
          end else if (bit_q == '0) begin
            state_d  = S_CS_HOLD;
            phase_d  = 1'b0;
            sdio_o_d = 1'b0;
          end else begin
            phase_d = 1'b0;
            bit_d   = bit_q - BIT_W'(1);
            if (!is_read_q) begin
              wd_d     = wd_q << 1;
              sdio_o_d = wd_d[DATA_WIDTH-1];
            end
          end
        end
      end
      S_CS_HOLD: begin
        if (tc) begin
          state_d     = S_CS_GAP;
          div_d       = DIV_LOAD;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = is_read_q ? rx_q : '0;
        end
      end
      S_CS_GAP: begin
        if (tc) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // pin outputs are decoded from next state so they register alongside it
    csn_d       = (state_d == S_IDLE) || (state_d == S_CS_GAP);
    sclk_d      = phase_d && ((state_d == S_HDR) || (state_d == S_DATA));
    sdio_t_d    = !((state_d == S_CS_SETUP) || (state_d == S_HDR) ||
                    ((state_d == S_DATA) && !is_read_d));
    busy_d      = (state_d != S_IDLE);
    cmd_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      bit_q       <= '0;
      phase_q     <= 1'b0;
      is_read_q   <= 1'b0;
      hdr_q       <= '0;
      wd_q        <= '0;
      rx_q        <= '0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      busy_q      <= 1'b0;
      csn_q       <= 1'b1;
      sclk_q      <= 1'b0;
      sdio_t_q    <= 1'b1;
      sdio_o_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      phase_q     <= phase_d;
      is_read_q   <= is_read_d;
      hdr_q       <= hdr_d;
      wd_q        <= wd_d;
      rx_q        <= rx_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      busy_q      <= busy_d;
      csn_q       <= csn_d;
      sclk_q      <= sclk_d;
      sdio_t_q    <= sdio_t_d;
      sdio_o_q    <= sdio_o_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign busy      = busy_q;
  assign spi_csn   = csn_q;
  assign spi_sclk  = sclk_q;
  assign sdio_t    = sdio_t_q;
  assign sdio_o    = sdio_o_q;

endmodule

// File: tb/tb_dx_spi3w_master.sv
// Bench for dx_spi3w_master: default-divider instance plus a CLK_DIV=1 instance,
// with an expected-response queue per instance and a pin monitor on the falling clock edge.
module tb_dx_spi3w_master;

  typedef struct {
    logic [7:0]  rdata;
    int          len;
    int          rises;
    logic [15:0] bits;
    int          t1;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       cmd_valid = 1'b0, cmd_ready, rsp_valid, busy;
  logic [7:0] cmd_hdr = '0, cmd_wdata = '0, rsp_rdata;
  logic       spi_csn, spi_sclk, sdio_t, sdio_o, sdio_i = 1'b0;

  logic       cmd_valid1 = 1'b0, cmd_ready1, rsp_valid1, busy1;
  logic [7:0] cmd_hdr1 = '0, cmd_wdata1 = '0, rsp_rdata1;
  logic       spi_csn1, spi_sclk1, sdio_t1, sdio_o1, sdio_i1;

  dx_spi3w_master #(.CMD_WIDTH(8), .DATA_WIDTH(8), .CLK_DIV(2)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_hdr(cmd_hdr), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .busy(busy), .spi_csn(spi_csn), .spi_sclk(spi_sclk),
    .sdio_t(sdio_t), .sdio_o(sdio_o), .sdio_i(sdio_i));

  dx_spi3w_master #(.CMD_WIDTH(8), .DATA_WIDTH(8), .CLK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
    .cmd_hdr(cmd_hdr1), .cmd_wdata(cmd_wdata1), .rsp_valid(rsp_valid1),
    .rsp_rdata(rsp_rdata1), .busy(busy1), .spi_csn(spi_csn1), .spi_sclk(spi_sclk1),
    .sdio_t(sdio_t1), .sdio_o(sdio_o1), .sdio_i(sdio_i1));

  // released line pulled high for the fast instance, so reads return all ones
  assign sdio_i1 = sdio_t1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  exp_t q[$];
  exp_t q1[$];
  logic [7:0] rd_pat = '0;

  // monitor state, default instance
  int lowcnt = 0, rises = 0, t1cnt = 0, drises = 0, gapcnt = 0;
  logic [15:0] bits = '0;
  logic prev_sclk = 1'b0, prev_csn = 1'b1, prev_sdo = 1'b0, seen = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      lowcnt = 0; rises = 0; t1cnt = 0; drises = 0; gapcnt = 0; bits = '0;
      seen = 1'b0; sdio_i = 1'b0;
    end else begin
      chk("rdy_busy", {31'd0, cmd_ready}, {31'd0, !busy});
      if (sdio_o !== prev_sdo) chk("sdo_edge", {31'd0, spi_sclk}, 32'd0);
      if (!spi_csn) begin
        lowcnt++;
        if (sdio_t) t1cnt++;
        if (spi_sclk && !prev_sclk) begin
          rises++;
          bits = {bits[14:0], sdio_o};
          if (sdio_t) drises++;
        end
      end
      if (!spi_csn && prev_csn) begin
        if (seen) chk("cs_gap", {31'd0, gapcnt >= 2}, 32'd1);
        seen = 1'b1;
        gapcnt = 0;
      end
      if (spi_csn) gapcnt++;
      if (rsp_valid) begin
        if (q.size() == 0) chk("rsp_spur", 32'd1, 32'd0);
        else begin
          e = q.pop_front();
          chk("rdata", {24'd0, rsp_rdata}, {24'd0, e.rdata});
          chk("csn_len", lowcnt, e.len);
          chk("sclk_rises", rises, e.rises);
          chk("bits", {16'd0, bits}, {16'd0, e.bits});
          chk("sdio_rel", t1cnt, e.t1);
        end
        lowcnt = 0; rises = 0; t1cnt = 0; drises = 0; bits = '0;
      end
      sdio_i = (!spi_csn && sdio_t && drises < 8) ? rd_pat[7 - drises] : 1'b0;
    end
    prev_sclk = spi_sclk;
    prev_csn  = spi_csn;
    prev_sdo  = sdio_o;
  end

  // monitor state, CLK_DIV=1 instance
  int low1 = 0, rises1 = 0;
  logic prev_sclk1 = 1'b0, prev_sdo1 = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      low1 = 0; rises1 = 0;
    end else begin
      chk("rdy_busy1", {31'd0, cmd_ready1}, {31'd0, !busy1});
      if (prev_sclk1) chk("sclk1_per", {31'd0, spi_sclk1}, 32'd0);
      if (sdio_o1 !== prev_sdo1) chk("sdo_edge1", {31'd0, spi_sclk1}, 32'd0);
      if (!spi_csn1) begin
        low1++;
        if (spi_sclk1 && !prev_sclk1) rises1++;
      end
      if (rsp_valid1) begin
        if (q1.size() == 0) chk("rsp_spur1", 32'd1, 32'd0);
        else begin
          e = q1.pop_front();
          chk("rdata1", {24'd0, rsp_rdata1}, {24'd0, e.rdata});
          chk("csn_len1", low1, e.len);
          chk("sclk_rises1", rises1, e.rises);
        end
        low1 = 0; rises1 = 0;
      end
    end
    prev_sclk1 = spi_sclk1;
    prev_sdo1  = sdio_o1;
  end

  task automatic send(input logic [7:0] h, input logic [7:0] w, input logic [7:0] pat,
                      input bit keep, input bit expect_rsp);
    bit   ok = 0;
    exp_t e;
    @(negedge clk);
    rd_pat    = pat;
    cmd_valid = 1'b1;
    cmd_hdr   = h;
    cmd_wdata = w;
    for (int n = 0; n < 400; n++) begin
      if (cmd_ready) begin
        @(posedge clk);
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("accept_to", 32'd0, 32'd1);
    else if (expect_rsp) begin
      e.rdata = h[7] ? pat : 8'h00;
      e.len   = h[7] ? 70 : 68;
      e.rises = 16;
      e.bits  = {h, h[7] ? 8'h00 : w};
      e.t1    = h[7] ? 36 : 2;
      q.push_back(e);
    end
    #1;
    cmd_valid = keep;
    cmd_hdr   = ~h;
    cmd_wdata = ~w;
  endtask

  task automatic wait_done();
    bit ok = 0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (q.size() == 0 && q1.size() == 0 && cmd_ready && cmd_ready1) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("done_to", q.size() + q1.size(), 32'd0);
  endtask

  initial begin
    exp_t e1;
    bit   ok;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_rspv",  {31'd0, rsp_valid}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_csn",   {31'd0, spi_csn}, 32'd1);
    chk("rst_sclk",  {31'd0, spi_sclk}, 32'd0);
    chk("rst_sdio_t", {31'd0, sdio_t}, 32'd1);
    chk("rst_sdio_o", {31'd0, sdio_o}, 32'd0);
    chk("rst_rdata", {24'd0, rsp_rdata}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    send(8'h12, 8'hA5, 8'h00, 0, 1);
    wait_done();
    send(8'h83, 8'h00, 8'h5C, 0, 1);
    wait_done();
    send(8'h01, 8'hFF, 8'h00, 0, 1);
    wait_done();
    send(8'hC0, 8'h77, 8'hA3, 0, 1);
    wait_done();
    chk("rdata_hold", {24'd0, rsp_rdata}, 32'hA3);

    // back-to-back with cmd_valid never dropped between the two commands
    send(8'h7F, 8'h00, 8'h00, 1, 1);
    send(8'h2A, 8'h96, 8'h00, 0, 1);
    wait_done();

    // reset in the middle of read data
    send(8'h83, 8'h00, 8'h3C, 0, 0);
    ok = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (drises >= 3) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("mid_data_to", 32'd0, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_csn",   {31'd0, spi_csn}, 32'd1);
    chk("mrst_sclk",  {31'd0, spi_sclk}, 32'd0);
    chk("mrst_sdio_t", {31'd0, sdio_t}, 32'd1);
    chk("mrst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("mrst_rspv",  {31'd0, rsp_valid}, 32'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("mrst_q", q.size(), 32'd0);

    // CLK_DIV=1 read of an all-ones line
    cmd_valid1 = 1'b1;
    cmd_hdr1   = 8'h83;
    ok = 0;
    for (int n = 0; n < 100; n++) begin
      if (cmd_ready1) begin
        @(posedge clk);
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("accept1_to", 32'd0, 32'd1);
    else begin
      e1.rdata = 8'hFF; e1.len = 35; e1.rises = 16; e1.bits = '0; e1.t1 = 0;
      q1.push_back(e1);
    end
    #1 cmd_valid1 = 1'b0;
    wait_done();

    repeat (5) @(negedge clk);
    chk("q_empty", q.size() + q1.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
